spu_fwd_stage_array: RTL and testbench

- Parametrised result-staging and forwarding array for the SPU issue pipes; generalises the fixed per-pipe 7-stage packed result chains to NUM_PIPES pipes of DEPTH stages.
- Adds cross-pipe forwarding across all pipes, per-read-port not-ready stall detection, partial flush, and writeback conflict resolution.
- Sits between the RF read stage (forward lookups) and the register file write ports (writeback from the final stage).

---
 rtl/spu_fwd_stage_array_if.sv | 36 +++
 rtl/spu_fwd_stage_array.sv | 125 ++++++++++++
 tb/tb_spu_fwd_stage_array.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spu_fwd_stage_array_if.sv
// Bundles the pipe result inputs, flush, forwarding lookups and writeback
// outputs of the SPU result-staging array.
// Handshake: none. Every field is qualified only by its own enable bit
// (in_wr, fwd_hit/fwd_stall, wb_en). The array advances on every clock edge
// and never back-pressures its producer.
interface spu_fwd_stage_array_if #(
    parameter int NUM_PIPES = 2,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int LAT_W     = 4,
    parameter int NUM_RD    = 6
);
    logic [NUM_PIPES-1:0]        in_wr;
    logic [NUM_PIPES*ADDR_W-1:0] in_addr;
    logic [NUM_PIPES*LAT_W-1:0]  in_lat;
    logic [NUM_PIPES*DATA_W-1:0] in_data;
    logic                        flush;
    logic [NUM_RD*ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0]           fwd_hit;
    logic [NUM_RD-1:0]           fwd_stall;
    logic [NUM_RD*DATA_W-1:0]    fwd_data;
    logic [NUM_PIPES-1:0]        wb_en;
    logic [NUM_PIPES*ADDR_W-1:0] wb_addr;
    logic [NUM_PIPES*DATA_W-1:0] wb_data;
    logic                        wb_conflict;

    modport master (
        output in_wr, in_addr, in_lat, in_data, flush, rd_addr,
        input  fwd_hit, fwd_stall, fwd_data, wb_en, wb_addr, wb_data, wb_conflict
    );

    modport slave (
        input  in_wr, in_addr, in_lat, in_data, flush, rd_addr,
        output fwd_hit, fwd_stall, fwd_data, wb_en, wb_addr, wb_data, wb_conflict
    );
endinterface

// File: rtl/spu_fwd_stage_array.sv
// Result-staging and forwarding array: NUM_PIPES pipes of DEPTH stages.
// Results enter stage 1 and shift one stage per clock. Lookups forward the
// newest in-flight result for an address, or report a stall when that result
// is not ready yet. Stage DEPTH drives the register-file write ports.
// Flat vectors place element k at slice k counted from the MSB end.
module spu_fwd_stage_array #(
    parameter int NUM_PIPES   = 2,
    parameter int DEPTH       = 7,
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 7,
    parameter int LAT_W       = 4,
    parameter int NUM_RD      = 6,
    parameter int FLUSH_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    spu_fwd_stage_array_if.slave bus
);
    // Index [p][s]: s = 0 is stage 1 and s = DEPTH-1 is stage DEPTH.
    logic              v_q    [NUM_PIPES][DEPTH];
    logic [ADDR_W-1:0] addr_q [NUM_PIPES][DEPTH];
    logic [LAT_W-1:0]  lat_q  [NUM_PIPES][DEPTH];
    logic [DATA_W-1:0] data_q [NUM_PIPES][DEPTH];

    // Latency of 0 means "ready at once". Values past DEPTH can never become
    // ready, so they are capped at DEPTH.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        logic [LAT_W-1:0] res;
        res = lat;
        if (lat == '0) begin
            res = LAT_W'(1);
        end else if (int'(lat) > DEPTH) begin
            res = LAT_W'(DEPTH);
        end
        return res;
    endfunction

    // Shift every pipe by one stage each edge. Flush drops the youngest stages
    // after the shift, which includes the entry captured on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    v_q[p][s]    <= 1'b0;
                    addr_q[p][s] <= '0;
                    lat_q[p][s]  <= '0;
                    data_q[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                v_q[p][0]    <= bus.in_wr[NUM_PIPES-1-p] && !bus.flush;
                addr_q[p][0] <= bus.in_addr[(NUM_PIPES-1-p)*ADDR_W +: ADDR_W];
                lat_q[p][0]  <= clamp_lat(bus.in_lat[(NUM_PIPES-1-p)*LAT_W +: LAT_W]);
                data_q[p][0] <= bus.in_data[(NUM_PIPES-1-p)*DATA_W +: DATA_W];
                for (int s = 1; s < DEPTH; s++) begin
                    v_q[p][s]    <= (bus.flush && (s < FLUSH_DEPTH)) ? 1'b0 : v_q[p][s-1];
                    addr_q[p][s] <= addr_q[p][s-1];
                    lat_q[p][s]  <= lat_q[p][s-1];
                    data_q[p][s] <= data_q[p][s-1];
                end
            end
        end
    end

    // Per read port, find the newest matching producer. Scanning oldest to
    // newest lets the last match win: lowest stage first, then highest pipe.
    always_comb begin : fwd_lookup
        logic              found;
        logic              rdy;
        logic [DATA_W-1:0] sel_data;
        logic [ADDR_W-1:0] ra;
        bus.fwd_hit   = '0;
        bus.fwd_stall = '0;
        bus.fwd_data  = '0;
        found         = 1'b0;
        rdy           = 1'b0;
        sel_data      = '0;
        ra            = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            found    = 1'b0;
            rdy      = 1'b0;
            sel_data = '0;
            ra       = bus.rd_addr[(NUM_RD-1-r)*ADDR_W +: ADDR_W];
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int p = 0; p < NUM_PIPES; p++) begin
                    if (v_q[p][s] && (addr_q[p][s] == ra)) begin
                        found    = 1'b1;
                        rdy      = ((s + 1) >= int'(lat_q[p][s]));
                        sel_data = data_q[p][s];
                    end
                end
            end
            bus.fwd_hit[NUM_RD-1-r]   = found && rdy;
            bus.fwd_stall[NUM_RD-1-r] = found && !rdy;
            if (found && rdy) begin
                bus.fwd_data[(NUM_RD-1-r)*DATA_W +: DATA_W] = sel_data;
            end
        end
    end

    // Writeback from the last stage. A same-address write from a higher pipe
    // is younger in program order, so it suppresses the lower pipe's enable.
    always_comb begin : wb_select
        logic keep;
        bus.wb_en       = '0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_conflict = 1'b0;
        keep            = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            keep = v_q[p][DEPTH-1];
            for (int q = p + 1; q < NUM_PIPES; q++) begin
                if (v_q[p][DEPTH-1] && v_q[q][DEPTH-1] &&
                    (addr_q[p][DEPTH-1] == addr_q[q][DEPTH-1])) begin
                    keep            = 1'b0;
                    bus.wb_conflict = 1'b1;
                end
            end
            bus.wb_en[NUM_PIPES-1-p]                        = keep;
            bus.wb_addr[(NUM_PIPES-1-p)*ADDR_W +: ADDR_W]   = addr_q[p][DEPTH-1];
            bus.wb_data[(NUM_PIPES-1-p)*DATA_W +: DATA_W]   = data_q[p][DEPTH-1];
        end
    end
endmodule

// File: tb/tb_spu_fwd_stage_array.sv
// Bench for spu_fwd_stage_array. The reference model is a queue of in-flight
// results tagged with their age in stages. Forwarding and writeback
// expectations come from that queue by the age/latency/program-order rules.
module tb_spu_fwd_stage_array;
    localparam int NP = 2;
    localparam int D  = 7;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int LW = 4;
    localparam int NR = 6;
    localparam int FD = 2;
    localparam int CW = NR * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spu_fwd_stage_array_if #(.NUM_PIPES(NP), .DATA_W(DW), .ADDR_W(AW),
                             .LAT_W(LW), .NUM_RD(NR)) bus ();

    spu_fwd_stage_array #(.NUM_PIPES(NP), .DEPTH(D), .DATA_W(DW), .ADDR_W(AW),
                          .LAT_W(LW), .NUM_RD(NR), .FLUSH_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int            pipe;
        logic          v;
        logic [AW-1:0] addr;
        int            lat;
        logic [DW-1:0] data;
        int            stage;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad   = 0;

    // One clock edge: everything ages by one stage, the inputs enter at
    // stage 1, and a flush invalidates the youngest FD stages.
    task automatic model_step();
        ent_t nq[$];
        ent_t e;
        foreach (mq[i]) begin
            e = mq[i];
            e.stage = e.stage + 1;
            if (e.stage <= D) nq.push_back(e);
        end
        for (int p = 0; p < NP; p++) begin
            e.pipe  = p;
            e.v     = bus.in_wr[NP-1-p];
            e.addr  = bus.in_addr[(NP-1-p)*AW +: AW];
            e.lat   = int'(bus.in_lat[(NP-1-p)*LW +: LW]);
            if (e.lat < 1) e.lat = 1;
            if (e.lat > D) e.lat = D;
            e.data  = bus.in_data[(NP-1-p)*DW +: DW];
            e.stage = 1;
            nq.push_back(e);
        end
        if (bus.flush) begin
            foreach (nq[i]) if (nq[i].stage <= FD) nq[i].v = 1'b0;
        end
        mq = nq;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NR-1:0]    eh;
        logic [NR-1:0]    es;
        logic [CW-1:0]    ed;
        logic [NP-1:0]    raw;
        logic [NP-1:0]    we;
        logic [NP*AW-1:0] wa;
        logic [NP*DW-1:0] wd;
        logic             wc;
        logic [AW-1:0]    ra;
        int               best;
        eh = '0; es = '0; ed = '0; raw = '0; wa = '0; wd = '0; wc = 1'b0;
        for (int r = 0; r < NR; r++) begin
            ra   = bus.rd_addr[(NR-1-r)*AW +: AW];
            best = -1;
            foreach (mq[i]) begin
                if (mq[i].v && mq[i].addr == ra) begin
                    if (best < 0 || mq[i].stage < mq[best].stage ||
                        (mq[i].stage == mq[best].stage && mq[i].pipe > mq[best].pipe))
                        best = i;
                end
            end
            if (best >= 0) begin
                if (mq[best].stage >= mq[best].lat) begin
                    eh[NR-1-r] = 1'b1;
                    ed[(NR-1-r)*DW +: DW] = mq[best].data;
                end else begin
                    es[NR-1-r] = 1'b1;
                end
            end
        end
        foreach (mq[i]) begin
            if (mq[i].stage == D) begin
                raw[NP-1-mq[i].pipe] = mq[i].v;
                wa[(NP-1-mq[i].pipe)*AW +: AW] = mq[i].addr;
                wd[(NP-1-mq[i].pipe)*DW +: DW] = mq[i].data;
            end
        end
        we = raw;
        for (int p = 0; p < NP; p++) begin
            for (int q = p + 1; q < NP; q++) begin
                if (raw[NP-1-p] && raw[NP-1-q] &&
                    wa[(NP-1-p)*AW +: AW] == wa[(NP-1-q)*AW +: AW]) begin
                    we[NP-1-p] = 1'b0;
                    wc = 1'b1;
                end
            end
        end
        chk({tag, "_hit"},   bus.fwd_hit,     eh);
        chk({tag, "_stall"}, bus.fwd_stall,   es);
        chk({tag, "_fdata"}, bus.fwd_data,    ed);
        chk({tag, "_wben"},  bus.wb_en,       we);
        chk({tag, "_wbadr"}, bus.wb_addr,     wa);
        chk({tag, "_wbdat"}, bus.wb_data,     wd);
        chk({tag, "_wbcf"},  bus.wb_conflict, wc);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: check, clock, advance model.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic wr, input logic [AW-1:0] a,
                         input int lat, input logic [DW-1:0] d);
        bus.in_wr[NP-1-p]              = wr;
        bus.in_addr[(NP-1-p)*AW +: AW] = a;
        bus.in_lat[(NP-1-p)*LW +: LW]  = LW'(lat);
        bus.in_data[(NP-1-p)*DW +: DW] = d;
    endtask

    task automatic set_rd(input int r, input logic [AW-1:0] a);
        bus.rd_addr[(NR-1-r)*AW +: AW] = a;
    endtask

    task automatic idle_in();
        bus.in_wr = '0;
        bus.flush = 1'b0;
    endtask

    task automatic rand_cycle();
        for (int p = 0; p < NP; p++)
            drive(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                  $urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom});
        for (int r = 0; r < NR; r++) set_rd(r, AW'($urandom_range(0, 7)));
        bus.flush = ($urandom_range(0, 15) == 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] aa;
        aa = {16{8'hAA}};
        rst = 1'b0;
        bus.in_wr = '0; bus.in_addr = '0; bus.in_lat = '0; bus.in_data = '0;
        bus.flush = 1'b0; bus.rd_addr = '0;

        // reset from power-up
        @(negedge clk);
        rst = 1'b1;
        #1;
        mq.delete();
        chk("rst0_wben", bus.wb_en, '0);
        chk("rst0_hit", bus.fwd_hit, '0);
        step("rst_hold");
        step("rst_hold");
        rst = 1'b0;
        step("post_rst");

        // single producer: pipe0 addr 5 lat 2
        drive(0, 1'b1, 7'd5, 2, aa);
        set_rd(0, 7'd5);
        step("sp_issue");
        idle_in();
        for (int k = 1; k <= D; k++) begin
            #1;
            if (k == 1) chk("sp_stall_s1", bus.fwd_stall[NR-1], 1'b1);
            else chk("sp_hit", {bus.fwd_hit[NR-1], bus.fwd_data[(NR-1)*DW +: DW]}, {1'b1, aa});
            if (k == D) chk("sp_wb", {bus.wb_en[NP-1], bus.wb_addr[(NP-1)*AW +: AW]}, {1'b1, 7'd5});
            step("sp_track");
        end
        step("sp_drain");

        // cross-pipe: pipe1 addr 9 lat 1 looked up on port 3
        drive(1, 1'b1, 7'd9, 1, 128'h55);
        set_rd(3, 7'd9);
        step("xp_issue");
        idle_in();
        #1;
        chk("xp_hit", {bus.fwd_hit[NR-1-3], bus.fwd_data[(NR-1-3)*DW +: DW]}, {1'b1, 128'h55});
        for (int k = 0; k < D; k++) step("xp_track");

        // newest-wins: older ready write then younger slow write to addr 3
        set_rd(0, 7'd3);
        drive(0, 1'b1, 7'd3, 1, 128'h1111);
        step("nw_old");
        idle_in();
        step("nw_gap");
        drive(1, 1'b1, 7'd3, 6, 128'h2222);
        step("nw_new");
        idle_in();
        #1;
        chk("nw_stall", {bus.fwd_hit[NR-1], bus.fwd_stall[NR-1]}, 2'b01);
        for (int k = 0; k < D + 1; k++) step("nw_track");

        // same-stage collision on addr 12
        set_rd(1, 7'd12);
        drive(0, 1'b1, 7'd12, 1, 128'h1);
        drive(1, 1'b1, 7'd12, 1, 128'h2);
        step("col_issue");
        idle_in();
        for (int k = 1; k <= D; k++) begin
            #1;
            if (k == 1) chk("col_fwd", bus.fwd_data[(NR-2)*DW +: DW], 128'h2);
            if (k == D) chk("col_wb", {bus.wb_en, bus.wb_conflict}, {2'b01, 1'b1});
            step("col_track");
        end
        step("col_drain");

        // flush with entries at stages 1..3 plus one on the inputs
        drive(0, 1'b1, 7'd6, 1, 128'h6);
        step("fl_a");
        drive(0, 1'b1, 7'd5, 1, 128'h5);
        step("fl_b");
        drive(0, 1'b1, 7'd4, 1, 128'h4);
        step("fl_c");
        drive(0, 1'b1, 7'd7, 1, 128'h7);
        bus.flush = 1'b1;
        step("fl_edge");
        idle_in();
        for (int k = 0; k < D + 1; k++) step("fl_track");

        // random traffic
        for (int n = 0; n < 300; n++) begin
            rand_cycle();
            step("rnd");
        end

        // reset mid-stream with results in flight
        for (int n = 0; n < 5; n++) begin
            rand_cycle();
            bus.flush = 1'b0;
            step("pre_rst");
        end
        rst = 1'b1;
        #1;
        mq.delete();
        chk("rstm_wben", bus.wb_en, '0);
        chk("rstm_hit", bus.fwd_hit, '0);
        step("rstm_hold");
        step("rstm_hold");
        rst = 1'b0;
        idle_in();
        for (int k = 0; k < D + 2; k++) step("rstm_drain");

        // more random traffic after reset
        for (int n = 0; n < 150; n++) begin
            rand_cycle();
            step("rnd2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
